// File: rtl/ddr_test_sequencer.sv
// ddr_test_sequencer: write-then-readback pattern test over the MIG app interface
module ddr_test_sequencer #(
   parameter int pDATA_WIDTH  = 128,
   parameter int pADDR_WIDTH  = 29,
   parameter int pADDR_INC    = 8,
   parameter int pCOUNT_WIDTH = 24,
   parameter int pTIMEOUT     = 4096
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [pADDR_WIDTH-1:0]  base_addr,
   input  logic [pCOUNT_WIDTH-1:0] word_count,
   input  logic                    pattern_mode,
   input  logic [31:0]             seed,
   input  logic                    init_calib_complete,
   output logic [pADDR_WIDTH-1:0]  app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [pDATA_WIDTH-1:0]  app_wdf_data,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   input  logic                    app_wdf_rdy,
   input  logic [pDATA_WIDTH-1:0]  app_rd_data,
   input  logic                    app_rd_data_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [15:0]             error_count,
   output logic [pADDR_WIDTH-1:0]  first_fail_addr
);
   localparam int tmr_w = $clog2(pTIMEOUT + 1);
   localparam int reps = pDATA_WIDTH / 32;
   localparam logic [pADDR_WIDTH-1:0] addr_inc = pADDR_WIDTH'(pADDR_INC);
   localparam logic [pCOUNT_WIDTH-1:0] cnt_one = pCOUNT_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DONE} state_t;

   state_t                  state;
   logic [pADDR_WIDTH-1:0]  base_r, caddr;
   logic [pCOUNT_WIDTH-1:0] cnt_r, wk, rk, ck;
   logic                    mode_r;
   logic [31:0]             seed_r, wpat, cpat, p0, wnext;
   logic [tmr_w-1:0]        tmr;
   logic                    w_done, outstanding, beat, miss;

   function automatic logic [31:0] next_pat(input logic m, input logic [31:0] p);
      return m ? ((p >> 1) ^ (p[0] ? 32'h80200003 : 32'h0)) : p + 32'd1;
   endfunction

   // pattern start value, word completion, read bookkeeping and compare
   always_comb begin
      p0          = (mode_r && seed_r == 32'h0) ? 32'h1 : seed_r;
      wnext       = next_pat(mode_r, wpat);
      w_done      = (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
      outstanding = rk != ck;
      beat        = app_rd_data_valid && ck != cnt_r;
      miss        = app_rd_data != {reps{cpat}};
   end

   assign app_wdf_end = app_wdf_wren;

   // test sequencer: config latch, write phase, read/check phase, status
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         base_r          <= '0;
         cnt_r           <= '0;
         mode_r          <= 1'b0;
         seed_r          <= '0;
         wpat            <= '0;
         cpat            <= '0;
         caddr           <= '0;
         wk              <= '0;
         rk              <= '0;
         ck              <= '0;
         tmr             <= '0;
         app_addr        <= '0;
         app_cmd         <= '0;
         app_en          <= 1'b0;
         app_wdf_data    <= '0;
         app_wdf_wren    <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         timeout         <= 1'b0;
         error_count     <= '0;
         first_fail_addr <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               base_r          <= base_addr;
               cnt_r           <= word_count;
               mode_r          <= pattern_mode;
               seed_r          <= seed;
               busy            <= 1'b1;
               done            <= 1'b0;
               pass            <= 1'b0;
               timeout         <= 1'b0;
               error_count     <= '0;
               first_fail_addr <= '0;
               state           <= (word_count == '0) ? DONE : WAIT_CAL;
            end
            WAIT_CAL: if (init_calib_complete) begin
               state        <= WRITE;
               app_en       <= 1'b1;
               app_cmd      <= 3'b000;
               app_addr     <= base_r;
               app_wdf_wren <= 1'b1;
               app_wdf_data <= {reps{p0}};
               wpat         <= p0;
               cpat         <= p0;
               caddr        <= base_r;
               wk           <= '0;
               rk           <= '0;
               ck           <= '0;
               tmr          <= '0;
            end
            WRITE: if (w_done) begin
               if (wk == cnt_r - cnt_one) begin
                  state        <= READ;
                  app_en       <= 1'b1;
                  app_cmd      <= 3'b001;
                  app_addr     <= base_r;
                  app_wdf_wren <= 1'b0;
               end else begin
                  wk           <= wk + cnt_one;
                  wpat         <= wnext;
                  app_wdf_data <= {reps{wnext}};
                  app_addr     <= app_addr + addr_inc;
                  app_en       <= 1'b1;
                  app_wdf_wren <= 1'b1;
               end
            end else begin
               app_en       <= app_en && !app_rdy;
               app_wdf_wren <= app_wdf_wren && !app_wdf_rdy;
            end
            READ: begin
               if (app_en && app_rdy) begin
                  rk       <= rk + cnt_one;
                  app_en   <= (rk + cnt_one) != cnt_r;
                  app_addr <= app_addr + addr_inc;
               end
               if (beat) begin
                  ck    <= ck + cnt_one;
                  cpat  <= next_pat(mode_r, cpat);
                  caddr <= caddr + addr_inc;
                  if (miss) begin
                     error_count <= error_count + {15'd0, error_count != 16'hFFFF};
                     if (error_count == '0) first_fail_addr <= caddr;
                  end
               end
               tmr <= (app_rd_data_valid || !outstanding) ? '0 : tmr + tmr_w'(1);
               if (ck == cnt_r && rk == cnt_r) state <= DONE;
               if (outstanding && !app_rd_data_valid && tmr == tmr_w'(pTIMEOUT - 1)) begin
                  timeout <= 1'b1;
                  app_en  <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               pass  <= error_count == '0 && !timeout;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ddr_test_sequencer.sv
// tb_ddr_test_sequencer: MIG model with scoreboard for ddr_test_sequencer
module tb_ddr_test_sequencer;
   typedef struct {logic [28:0] a; logic [127:0] d;} wr_t;
   typedef struct {logic [28:0] a; int due;} rd_t;
   typedef struct {logic pass; logic to; logic [15:0] err; logic [28:0] ffa;} st_t;

   logic         clk = 1'b0;
   logic         reset_n, start, pattern_mode, init_calib_complete;
   logic [28:0]  base_addr, app_addr, first_fail_addr;
   logic [23:0]  word_count;
   logic [31:0]  seed;
   logic [2:0]   app_cmd;
   logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
   logic [127:0] app_wdf_data, app_rd_data;
   logic         busy, done, pass, timeout;
   logic [15:0]  error_count;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int ncmd = 0, ndat = 0, rbeat = 0, corrupt = -1, drop = -1, last_vcyc = 0;
   logic bp = 1'b0;
   wr_t wq[$];
   st_t sq[$];
   rd_t rp[$];
   logic [28:0]  ca[$];
   logic [127:0] cd[$];
   logic [127:0] mem [logic [28:0]];
   rd_t  r;
   wr_t  we;
   logic [28:0]  wa;
   logic [127:0] wd;

   ddr_test_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .pattern_mode(pattern_mode), .seed(seed),
      .init_calib_complete(init_calib_complete), .app_addr(app_addr), .app_cmd(app_cmd),
      .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .busy(busy),
      .done(done), .pass(pass), .timeout(timeout), .error_count(error_count),
      .first_fail_addr(first_fail_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // MIG model: ready values and read data set on negedge, handshakes land on the next posedge
   always @(negedge clk) begin
      app_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      app_rd_data_valid = 1'b0;
      if (app_en && app_rdy) begin
         if (app_cmd == 3'b000) begin
            ca.push_back(app_addr);
            ncmd++;
         end else rp.push_back('{app_addr, cyc + 20});
      end
      if (app_wdf_wren && app_wdf_rdy) begin
         cd.push_back(app_wdf_data);
         ndat++;
         chk("wdf_end", app_wdf_end, 1);
      end
      while (ca.size() > 0 && cd.size() > 0) begin
         wa = ca.pop_front();
         wd = cd.pop_front();
         mem[wa] = wd;
         if (wq.size() > 0) begin
            we = wq.pop_front();
            chk("waddr", wa, we.a);
            chk("wdata", wd, we.d);
         end else chk("wr_extra", 1, 0);
      end
      if (rp.size() > 0 && rp[0].due <= cyc) begin
         r = rp.pop_front();
         if (rbeat != drop) begin
            app_rd_data = mem.exists(r.a) ? mem[r.a] : '0;
            if (rbeat == corrupt) app_rd_data = app_rd_data ^ 128'h1;
            app_rd_data_valid = 1'b1;
            last_vcyc = cyc;
         end
         rbeat++;
      end
   end

   task automatic run(input logic [28:0] b, input logic [23:0] n, input logic m,
                      input logic [31:0] s, input int cor, input int drp);
      logic [31:0] p;
      st_t st;
      p = (m && s == 32'h0) ? 32'h1 : s;
      for (int k = 0; k < int'(n); k++) begin
         wq.push_back('{b + 29'(k * 8), {4{p}}});
         p = m ? ((p >> 1) ^ (p[0] ? 32'h80200003 : 32'h0)) : p + 32'd1;
      end
      st.err = (cor >= 0 && cor < int'(n)) ? 16'd1 : 16'd0;
      st.ffa = (cor >= 0) ? b + 29'(cor * 8) : '0;
      st.to = drp >= 0;
      st.pass = st.err == 16'd0 && !st.to;
      sq.push_back(st);
      corrupt = cor;
      drop = drp;
      rbeat = 0;
      base_addr = b;
      word_count = n;
      pattern_mode = m;
      seed = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string t);
      int i;
      st_t e;
      i = 0;
      while (!done && i < 20000) begin
         @(negedge clk);
         i++;
      end
      chk({t, "_done"}, done, 1);
      if (sq.size() > 0) begin
         e = sq.pop_front();
         chk({t, "_pass"}, pass, e.pass);
         chk({t, "_err"}, error_count, e.err);
         chk({t, "_ffa"}, first_fail_addr, e.ffa);
         chk({t, "_timeout"}, timeout, e.to);
      end else chk({t, "_sq"}, 0, 1);
      chk({t, "_busy"}, busy, 0);
      chk({t, "_wq_left"}, wq.size(), 0);
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_strobes"}, {app_en, app_wdf_wren, app_wdf_end}, 0);
      chk({t, "_status"}, {busy, done, pass, timeout}, 0);
      chk({t, "_err"}, error_count, 0);
      chk({t, "_ffa"}, first_fail_addr, 0);
      chk({t, "_addr"}, app_addr, 0);
      chk({t, "_cmd"}, app_cmd, 0);
      chk({t, "_wdata"}, app_wdf_data, 0);
   endtask

   initial begin
      int i;
      reset_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      word_count = '0;
      pattern_mode = 1'b0;
      seed = '0;
      init_calib_complete = 1'b0;
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      app_rd_data = '0;
      app_rd_data_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // 1: incrementing, calibration arrives late
      run(29'h0, 24'd4, 1'b0, 32'h100, -1, -1);
      repeat (4) @(negedge clk);
      chk("t1_wait_cal_busy", busy, 1);
      chk("t1_wait_cal_en", {app_en, app_wdf_wren}, 0);
      init_calib_complete = 1'b1;
      wait_done("t1");

      // 2: corrupted read of word 2
      run(29'h0, 24'd4, 1'b0, 32'h100, 2, -1);
      wait_done("t2");

      // 3: LFSR with zero seed
      run(29'h40, 24'd3, 1'b1, 32'h0, -1, -1);
      wait_done("t3");

      // 4: random back-pressure on both channels
      ncmd = 0;
      ndat = 0;
      bp = 1'b1;
      run(29'h1FFF_FFC0, 24'd64, 1'b1, 32'hACE1_2345, -1, -1);
      wait_done("t4");
      chk("t4_ncmd", ncmd, 64);
      chk("t4_ndat", ndat, 64);
      bp = 1'b0;

      // 5: dropped last beat leads to timeout, then zero-length test
      run(29'h100, 24'd4, 1'b0, 32'h7, -1, 3);
      i = 0;
      while (!timeout && i < 8000) begin
         @(negedge clk);
         i++;
      end
      chk("t5_to_latency", cyc - last_vcyc - 1, 4096);
      wait_done("t5");
      run(29'h100, 24'd0, 1'b0, 32'h7, -1, -1);
      chk("t5z_cleared", {done, timeout, busy}, 3'b001);
      @(negedge clk);
      chk("t5z_done_pass", {done, pass, busy}, 3'b110);
      wait_done("t5z");

      // 6: reset mid-read, then a start while busy is dropped
      run(29'h1000, 24'd16, 1'b0, 32'h55, -1, -1);
      i = 0;
      while (!(app_en && app_cmd == 3'b001) && i < 2000) begin
         @(negedge clk);
         i++;
      end
      chk("t6_in_read", app_cmd, 3'b001);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_zero("t6_reset");
      reset_n = 1'b1;
      sq.delete();
      wq.delete();
      repeat (60) @(negedge clk);
      run(29'h2000, 24'd8, 1'b1, 32'h1234_5678, -1, -1);
      repeat (5) @(negedge clk);
      seed = 32'hDEAD_BEEF;
      word_count = 24'd3;
      base_addr = 29'h3000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t6");
      repeat (20) @(negedge clk);
      chk("t6_no_queue", {busy, done}, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
